vec_sweep_gen: RTL and testbench
================================

# vec_sweep_gen

Sequential vector sweeper that sits directly upstream of the two-level select/combine stage (`comb_str2`). It drives that stage's `sel`, `A`, `B`, `C`, `D` inputs through all 32 combinations. It holds each vector for a fixed number of clocks and samples the stage's `Y` output at the end of each hold window. The result is a 32-bit response signature plus a ones count, so the combinational stage can be exercised in-system without an external stimulus source.

## Interface
- `HOLD`, default 10: clocks each vector is held. Legal range 1..255.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  begins a sweep when sampled high in IDLE or DONE.
- `abort`  input  1  ends a sweep in progress and returns to IDLE.
- `Y`  input  1  response from the downstream stage.
- `sel`, `A`, `B`, `C`, `D`  output  1 each  registered vector to the downstream stage.
- `busy`  output  1  high while a sweep is running.
- `done`  output  1  high from sweep completion until the next `start` or `abort`.
- `sig`  output  32  `sig[i]` holds the `Y` sampled for vector index i.
- `ones_cnt`  output  6  number of 1s captured in the current or last sweep (0..32).

## Operation
- Vector mapping for index `idx[4:0]`: `sel`=idx[4], `A`=idx[3], `B`=idx[2], `C`=idx[1], `D`=idx[0]. Sweep order is ascending, 0..31.
- States:
  - IDLE: vector outputs are 0.
  - APPLY: a vector is being driven.
  - DONE: sweep complete.
- IDLE or DONE, `start`=1:
  - Go to APPLY with `idx`=0 and hold counter=`HOLD`-1.
  - Clear `sig`, `ones_cnt` and `done`.
- APPLY with counter≠0: decrement the counter.
- APPLY with counter=0:
  - Set `sig[idx]`←`Y` and `ones_cnt`←`ones_cnt`+`Y`.
  - If `idx`=31, go to DONE. Otherwise `idx`+1 and reload the counter.
- DONE: hold the last vector (all 1s), `sig` and `ones_cnt` until `start` or `abort`.
- `abort` in any state:
  - Go to IDLE with vector 0 and `done`=0.
  - `sig` and `ones_cnt` keep their partial values.
  - `abort` has priority over `start` in the same cycle.
- `start` while in APPLY is ignored.
- `ones_cnt` is 6 bits so a count of 32 does not wrap.

## Timing
- Reset values: `sel`=`A`=`B`=`C`=`D`=0, `busy`=0, `done`=0, `sig`=32'h0, `ones_cnt`=0, state IDLE. Reset takes effect asynchronously; release is synchronous to `clk`.
- Reset mid-sweep discards all progress immediately.
- `start` sampled at edge k:
  - `busy`=1 and vector 0 are driven after edge k.
  - Vector i is stable for exactly `HOLD` cycles, from edge k+i·`HOLD` to edge k+(i+1)·`HOLD`.
- `Y` is sampled at the edge that ends each window. At that same edge the next vector is loaded. This gives `HOLD` cycles of settle time through the combinational stage.
- The last sample is taken at edge k+32·`HOLD`. At that edge `busy`→0, `done`→1 and the final `sig`/`ones_cnt` become visible.
- `HOLD`=1: a new vector every cycle, with each `Y` sampled one cycle after its vector is applied.

## Structure
- Shared package/header `vec_sweep_pkg` holds:
  - state encodings `ST_IDLE`, `ST_APPLY`, `ST_DONE`;
  - `NVEC`=32;
  - `IDX_W`=5.
- One sub-module, `hold_timer`: a loadable down-counter of width clog2(`HOLD`), minimum 1. Ports: `load`, `en`, `zero`.
- Top level contains the FSM, the `idx` register, the `sig` capture register and `ones_cnt`.

## Test plan
- `HOLD`=2, `Y` tied to `D`, pulse `start` at edge k → `done` rises at edge k+64; `sig`=32'hAAAAAAAA; `ones_cnt`=16.
- `HOLD`=2, `Y` driven as `A`&~`sel` → `sig`=32'h0000FF00; `ones_cnt`=8. Vector outputs are checked each cycle against `idx`, each value lasting exactly 2 cycles.
- `HOLD`=1, `Y` tied to `sel` → `sig`=32'hFFFF0000 at edge k+32; `ones_cnt`=16. A second `start` in DONE clears `sig` to 0 at the next edge, then the sweep repeats identically.
- `HOLD`=3, `Y`=1, `start` re-pulsed at edge k+10 → ignored; `done` still rises at edge k+96 with `ones_cnt`=32 and `sig`=32'hFFFFFFFF.
- `HOLD`=2, `Y`=1, `abort` at edge k+9 → IDLE, vector 0, `busy`=0, `done`=0, `ones_cnt`=4, `sig`=32'h0000000F. `abort` and `start` together → stays IDLE.
- `rst_n` pulled low asynchronously mid-sweep (between edges) → all outputs are 0 immediately. After release, a `start` runs a full sweep correctly.

Source files
------------

// File: rtl/vec_sweep_pkg.sv
// Shared definitions for the vector sweeper: state encoding, sweep size
// and the hold-timer width helper.
package vec_sweep_pkg;

  localparam int NVEC  = 32;
  localparam int IDX_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Hold timer width: clog2(hold), never less than one bit.
  function automatic int timer_width(input int hold);
    return ($clog2(hold) < 1) ? 1 : $clog2(hold);
  endfunction

endpackage

// File: rtl/vec_sweep_if.sv
// Bus between the sweeper and the downstream select/combine stage.
// There is no handshake on this bus: the master drives a registered
// vector (sel, A, B, C, D) and holds it for a whole window; the slave
// answers combinationally on Y, which the master samples at the end of
// the window. No valid/ready qualifiers are needed because the sweeper
// owns all timing.
interface vec_sweep_if;
  logic sel;
  logic A;
  logic B;
  logic C;
  logic D;
  logic Y;

  modport master (output sel, output A, output B, output C, output D, input Y);
  modport slave  (input sel, input A, input B, input C, input D, output Y);
endinterface

// File: rtl/hold_timer.sv
// Loadable down-counter that measures how long each vector is held.
// It stops at zero and stays there until the next load.
module hold_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] i_load_val,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  // Load has priority; otherwise count down while enabled and not at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= i_load_val;
    end else if (en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/vec_sweep_gen.sv
// Sweeps the 32 input combinations of the downstream select/combine stage,
// holding each for HOLD clocks and capturing Y at the end of every window
// into a 32-bit signature plus a ones count.
module vec_sweep_gen
  import vec_sweep_pkg::*;
#(
  parameter int HOLD = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic [NVEC-1:0]    sig,
  output logic [5:0]         ones_cnt,
  output state_t             o_dbg_state,
  vec_sweep_if.master        bus
);

  localparam int            CW     = timer_width(HOLD);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NVEC - 1);

  state_t            r_state;
  state_t            w_next;
  logic [IDX_W-1:0]  r_idx;
  logic [NVEC-1:0]   r_sig;
  logic [5:0]        r_ones;

  logic w_load;
  logic w_clear;
  logic w_capture;
  logic w_adv;
  logic w_idx_rst;
  logic w_zero;
  logic w_en;

  assign w_en = (r_state == ST_APPLY);

  hold_timer #(
    .W (CW)
  ) u_hold_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (w_load),
    .en         (w_en),
    .i_load_val (RELOAD),
    .zero       (w_zero)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and datapath controls; abort overrides everything, start is
  // only honoured outside APPLY.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_clear   = 1'b0;
    w_capture = 1'b0;
    w_adv     = 1'b0;
    w_idx_rst = 1'b0;
    if (abort) begin
      w_next    = ST_IDLE;
      w_idx_rst = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_next    = ST_APPLY;
            w_load    = 1'b1;
            w_clear   = 1'b1;
            w_idx_rst = 1'b1;
          end
        end
        ST_APPLY: begin
          if (w_zero) begin
            w_capture = 1'b1;
            if (r_idx == LAST_IDX) begin
              w_next = ST_DONE;
            end else begin
              w_adv  = 1'b1;
              w_load = 1'b1;
            end
          end
        end
        default: begin
          w_next    = ST_IDLE;
          w_idx_rst = 1'b1;
        end
      endcase
    end
  end

  // Vector index, response signature and ones count. Abort leaves the
  // partial signature and count in place; only a new start clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx  <= '0;
      r_sig  <= '0;
      r_ones <= '0;
    end else begin
      if (w_idx_rst) begin
        r_idx <= '0;
      end else if (w_adv) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_clear) begin
        r_sig  <= '0;
        r_ones <= '0;
      end else if (w_capture) begin
        r_sig[r_idx] <= bus.Y;
        r_ones       <= r_ones + {5'd0, bus.Y};
      end
    end
  end

  // The vector is the index register itself: 0 in IDLE, 31 held in DONE.
  assign bus.sel = r_idx[4];
  assign bus.A   = r_idx[3];
  assign bus.B   = r_idx[2];
  assign bus.C   = r_idx[1];
  assign bus.D   = r_idx[0];

  assign busy        = (r_state == ST_APPLY);
  assign done        = (r_state == ST_DONE);
  assign sig         = r_sig;
  assign ones_cnt    = r_ones;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_vec_sweep_gen.sv
// Bench for vec_sweep_gen: three instances (HOLD = 2, 1, 3), each with a
// small stand-in for the downstream stage selectable per test.
module tb_vec_sweep_gen;
  import vec_sweep_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT hookup ----------------
  logic [2:0]  start_v = '0;
  logic [2:0]  abort_v = '0;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [31:0] sig_a  [3];
  logic [5:0]  ones_a [3];
  state_t      st_a   [3];
  logic [1:0]  mode   [3];
  logic [4:0]  vec_a  [3];

  vec_sweep_if b0 ();
  vec_sweep_if b1 ();
  vec_sweep_if b2 ();

  // Downstream stand-in: 0 Y=D, 1 Y=A&~sel, 2 Y=sel, 3 Y=1. v = {sel,A,B,C,D}.
  function automatic logic y_fn(input logic [1:0] m, input logic [4:0] v);
    case (m)
      2'd0:    return v[0];
      2'd1:    return v[3] & ~v[4];
      2'd2:    return v[4];
      default: return 1'b1;
    endcase
  endfunction

  assign vec_a[0] = {b0.sel, b0.A, b0.B, b0.C, b0.D};
  assign vec_a[1] = {b1.sel, b1.A, b1.B, b1.C, b1.D};
  assign vec_a[2] = {b2.sel, b2.A, b2.B, b2.C, b2.D};
  assign b0.Y = y_fn(mode[0], vec_a[0]);
  assign b1.Y = y_fn(mode[1], vec_a[1]);
  assign b2.Y = y_fn(mode[2], vec_a[2]);

  vec_sweep_gen #(.HOLD(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .abort(abort_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .sig(sig_a[0]), .ones_cnt(ones_a[0]),
    .o_dbg_state(st_a[0]), .bus(b0)
  );
  vec_sweep_gen #(.HOLD(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .abort(abort_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .sig(sig_a[1]), .ones_cnt(ones_a[1]),
    .o_dbg_state(st_a[1]), .bus(b1)
  );
  vec_sweep_gen #(.HOLD(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .abort(abort_v[2]),
    .busy(busy_v[2]), .done(done_v[2]), .sig(sig_a[2]), .ones_cnt(ones_a[2]),
    .o_dbg_state(st_a[2]), .bus(b2)
  );

  // ---------------- scoreboard ----------------
  // Entry: {inst[1:0], latency[15:0], ones[5:0], sig[31:0]}
  localparam int W = 56;
  logic [W-1:0] exp_q[$];
  int start_k [3];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int i, input int lat, input int ones, input logic [31:0] s);
    logic [W-1:0] e;
    e = {i[1:0], lat[15:0], ones[5:0], s};
    exp_q.push_back(e);
  endtask

  // Pops one expectation each time some instance raises done.
  task automatic monitor_loop();
    logic [2:0]   prev_done;
    logic [W-1:0] e;
    prev_done = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst_n && done_v[i] && !prev_done[i]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 64'(i), 64'hFF);
          end else begin
            e = exp_q.pop_front();
            chk("done_inst",    64'(i),                  64'(e[55:54]));
            chk("done_latency", 64'(cyc - start_k[i]),   64'(e[53:38]));
            chk("ones_cnt",     64'(ones_a[i]),          64'(e[37:32]));
            chk("sig",          64'(sig_a[i]),           64'(e[31:0]));
          end
        end
        prev_done[i] = done_v[i];
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Start sampled at edge k; returns at the negedge right after edge k.
  task automatic pulse_start(input int i);
    @(negedge clk);
    start_v[i] = 1'b1;
    @(negedge clk);
    start_v[i] = 1'b0;
    start_k[i] = cyc;
  endtask

  task automatic wait_done(input int i, input int budget);
    int n;
    n = 0;
    while (!done_v[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", 64'(done_v[i]), 64'd1);
  endtask

  task automatic run_tests();
    // Reset values, applied asynchronously before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_vec",   64'(vec_a[i]),  64'd0);
      chk("rst_busy",  64'(busy_v[i]), 64'd0);
      chk("rst_done",  64'(done_v[i]), 64'd0);
      chk("rst_sig",   64'(sig_a[i]),  64'd0);
      chk("rst_ones",  64'(ones_a[i]), 64'd0);
      chk("rst_state", 64'(st_a[i]),   64'(ST_IDLE));
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // HOLD=2, Y=D.
    mode[0] = 2'd0;
    push_exp(0, 64, 16, 32'hAAAAAAAA);
    pulse_start(0);
    wait_done(0, 200);

    // HOLD=2, Y=A&~sel, vector checked every cycle of the sweep.
    @(negedge clk);
    mode[0] = 2'd1;
    push_exp(0, 64, 8, 32'h0000FF00);
    pulse_start(0);
    for (int j = 0; j < 64; j++) begin
      if (j != 0) @(negedge clk);
      chk("vec_walk", 64'(vec_a[0]), 64'(j >> 1));
      chk("busy_walk", 64'(busy_v[0]), 64'd1);
    end
    wait_done(0, 10);
    chk("done_vec", 64'(vec_a[0]), 64'h1F);

    // HOLD=1, Y=sel, then a second start from DONE.
    mode[1] = 2'd2;
    push_exp(1, 32, 16, 32'hFFFF0000);
    pulse_start(1);
    wait_done(1, 100);
    push_exp(1, 32, 16, 32'hFFFF0000);
    pulse_start(1);
    chk("restart_sig",  64'(sig_a[1]),  64'd0);
    chk("restart_ones", 64'(ones_a[1]), 64'd0);
    chk("restart_done", 64'(done_v[1]), 64'd0);
    chk("restart_busy", 64'(busy_v[1]), 64'd1);
    wait_done(1, 100);

    // HOLD=3, Y=1, start re-pulsed at edge k+10 must be ignored.
    mode[2] = 2'd3;
    push_exp(2, 96, 32, 32'hFFFFFFFF);
    pulse_start(2);
    repeat (9) @(negedge clk);
    start_v[2] = 1'b1;
    @(negedge clk);
    start_v[2] = 1'b0;
    chk("ignored_start_vec", 64'(vec_a[2]), 64'd3);
    wait_done(2, 200);

    // HOLD=2, Y=1, abort sampled at edge k+9.
    mode[0] = 2'd3;
    pulse_start(0);
    repeat (8) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    chk("abort_state", 64'(st_a[0]),   64'(ST_IDLE));
    chk("abort_vec",   64'(vec_a[0]),  64'd0);
    chk("abort_busy",  64'(busy_v[0]), 64'd0);
    chk("abort_done",  64'(done_v[0]), 64'd0);
    chk("abort_ones",  64'(ones_a[0]), 64'd4);
    chk("abort_sig",   64'(sig_a[0]),  64'h0000000F);
    // abort together with start: abort wins, nothing is cleared.
    abort_v[0] = 1'b1;
    start_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    start_v[0] = 1'b0;
    chk("abort_start_state", 64'(st_a[0]),   64'(ST_IDLE));
    chk("abort_start_busy",  64'(busy_v[0]), 64'd0);
    chk("abort_start_ones",  64'(ones_a[0]), 64'd4);
    chk("abort_start_sig",   64'(sig_a[0]),  64'h0000000F);

    // Asynchronous reset in the middle of a sweep.
    mode[0] = 2'd0;
    pulse_start(0);
    repeat (20) @(negedge clk);
    chk("pre_reset_sig", 64'(sig_a[0]), 64'h000002AA);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_vec",  64'(vec_a[0]),  64'd0);
    chk("mid_rst_busy", 64'(busy_v[0]), 64'd0);
    chk("mid_rst_sig",  64'(sig_a[0]),  64'd0);
    chk("mid_rst_ones", 64'(ones_a[0]), 64'd0);
    chk("mid_rst_done", 64'(done_v[1]), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    push_exp(0, 64, 16, 32'hAAAAAAAA);
    pulse_start(0);
    wait_done(0, 200);

    repeat (2) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- main / report ----------------
  initial begin
    for (int i = 0; i < 3; i++) begin
      mode[i]    = 2'd0;
      start_k[i] = 0;
    end
    fork
      monitor_loop();
      run_tests();
    join_any
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
